branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Branch/control-flow generator on the driving side of the program counter: produces the Branch, UnconditionalBranch and Target inputs that ProgCtr consumes.
- Holds a registered compare-flag pair, a target lookup table (LUT) loaded by software/bench, and a small return-address stack for call/return.
- Tracks program run state (idle/run/done) so redirects are only issued while a program is executing.

Parameters:
- PC_W, 8, program counter / target width
- LUT_AW, 4, LUT index width (2**LUT_AW entries)
- STK_DEPTH, 4, return-address stack entries

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; priority over every other input
- Start  in  1  program start pulse (same signal fed to ProgCtr)
- ProgCtr  in  PC_W  current PC (source of return address)
- OpBr  in  1  conditional branch this cycle
- OpJmp  in  1  unconditional jump
- OpCall  in  1  call (jump + push return address)
- OpRet  in  1  return (jump to popped address)
- OpCmp  in  1  update flags from CmpA/CmpB
- OpHalt  in  1  end of program
- CondSel  in  2  00 EQ, 01 NE, 10 LT (unsigned), 11 GE (unsigned)
- CmpA, CmpB  in  8  compare operands
- LutIdx  in  LUT_AW  LUT index for Br/Jmp/Call target and for LUT writes
- LutWe  in  1  LUT write enable
- LutWData  in  PC_W  LUT write data
- Branch  out  1  redirect PC this cycle
- UnconditionalBranch  out  1  redirect is unconditional (jmp/call/ret)
- Target  out  PC_W  redirect address (absolute)
- Running  out  1  state == RUN
- Done  out  1  state == DONE
- StackErr  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset: state IDLE; flags Z=C=0; stack pointer 0; StackErr 0; all LUT entries 0. Outputs Branch=UB=0, Target=0, Running=0, Done=0. Reset mid-run aborts immediately, and Start is ignored in the same cycle.
- FSM:
  - IDLE: Start -> RUN.
  - RUN: OpHalt -> DONE; Start -> RUN with flags, stack pointer and StackErr cleared.
  - DONE: Start -> RUN with the same clears. Otherwise hold.
- Branch, UnconditionalBranch and Target are combinational from the Op inputs, registered flags, LUT and stack top, and are gated by state==RUN (all 0 otherwise). Zero-cycle latency: ProgCtr samples them on the same edge.
- Op priority when several are asserted: Halt > Ret > Call > Jmp > Br. OpCmp is independent and may accompany any other op.
- Halt: no redirect.
- Jmp: Branch=1, UB=1, Target=LUT[LutIdx].
- Br: taken when the condition on the *registered* flags holds (EQ: Z, NE: !Z, LT: C, GE: !C).
  - Taken: Branch=1, UB=0, Target=LUT[LutIdx].
  - Not taken: all outputs 0.
  - OpCmp in the same cycle affects only later branches.
- OpCmp in RUN: at the edge, Z<=(CmpA==CmpB), C<=(CmpA<CmpB unsigned). Ignored outside RUN.
- Call: Branch=1, UB=1, Target=LUT[LutIdx]; pushes (ProgCtr+1) mod 2**PC_W.
  - Full stack: the jump still occurs, nothing is pushed, StackErr<=1.
- Ret: stack non-empty gives Branch=1, UB=1, Target=stack top; the top is popped at the edge.
  - Empty stack: outputs 0 (fall through), StackErr<=1.
- StackErr is sticky until Reset or Start.
- LUT write: when LutWe=1, LUT[LutIdx]<=LutWData at the edge in any state. A same-cycle read of that entry returns the old value.

Test Plan:
- Reset 2 cycles, load LUT[3]=100 in IDLE, pulse Start, then OpJmp with LutIdx=3 -> Branch=1, UB=1, Target=100 in that cycle. Running=1. Asserting OpJmp before Start -> all outputs 0.
- OpCmp A=5, B=5, then next cycle OpBr CondSel=EQ, LUT[2]=40 -> Branch=1, UB=0, Target=40. Same with CondSel=NE -> Branch=0. OpCmp(5,5) together with OpBr(EQ) directly after Reset+Start -> not taken, because old Z=0 is used.
- OpCmp A=3, B=9: LT taken (Branch=1); GE not taken.
- ProgCtr=10, OpCall with LUT[1]=60 -> Target=60; later OpRet -> Target=11, UB=1. Five nested calls with STK_DEPTH=4 -> 5th still jumps and StackErr=1. OpRet on empty stack -> Branch=0, StackErr=1.
- ProgCtr=255 call -> return Target=0 (wrap).
- OpHalt in RUN -> Done=1, Running=0 next cycle, and a subsequent OpJmp gives no redirect. Start -> RUN with StackErr cleared. Reset asserted mid-RUN together with Start -> IDLE next cycle, all outputs 0, LUT cleared.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// Handshake bundle between the program sequencer and branch_ctrl.
// The master side drives ops/operands; the slave side returns the PC redirect.
interface branch_ctrl_if #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned LUT_AW = 4
);
  logic              Start;
  logic [PC_W-1:0]   ProgCtr;
  logic              OpBr;
  logic              OpJmp;
  logic              OpCall;
  logic              OpRet;
  logic              OpCmp;
  logic              OpHalt;
  logic [1:0]        CondSel;
  logic [7:0]        CmpA;
  logic [7:0]        CmpB;
  logic [LUT_AW-1:0] LutIdx;
  logic              LutWe;
  logic [PC_W-1:0]   LutWData;
  logic              Branch;
  logic              UnconditionalBranch;
  logic [PC_W-1:0]   Target;
  logic              Running;
  logic              Done;
  logic              StackErr;

  modport master (
    output Start, ProgCtr, OpBr, OpJmp, OpCall, OpRet, OpCmp, OpHalt,
    output CondSel, CmpA, CmpB, LutIdx, LutWe, LutWData,
    input  Branch, UnconditionalBranch, Target, Running, Done, StackErr
  );

  modport slave (
    input  Start, ProgCtr, OpBr, OpJmp, OpCall, OpRet, OpCmp, OpHalt,
    input  CondSel, CmpA, CmpB, LutIdx, LutWe, LutWData,
    output Branch, UnconditionalBranch, Target, Running, Done, StackErr
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch/control-flow generator feeding ProgCtr: compare flags, target LUT,
// return-address stack and idle/run/done program state.
module branch_ctrl #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned LUT_AW    = 4,
  parameter int unsigned STK_DEPTH = 4
) (
  input logic          Clk,
  input logic          Reset,
  branch_ctrl_if.slave bus
);

  localparam int unsigned LutDepth = 2 ** LUT_AW;
  localparam int unsigned SpW      = $clog2(STK_DEPTH + 1);
  localparam int unsigned StkAW    = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic            z_q, z_d;
  logic            c_q, c_d;
  logic [SpW-1:0]  sp_q, sp_d;
  logic            serr_q, serr_d;
  logic [PC_W-1:0] lut_q [LutDepth];
  logic [PC_W-1:0] stk_q [STK_DEPTH];

  logic            in_run;
  logic            act_ret, act_call, act_jmp, act_br;
  logic            stk_empty, stk_full;
  logic [SpW-1:0]  sp_top;
  logic [PC_W-1:0] lut_rd, stk_top, push_val;
  logic            cond_taken;
  logic            start_clear;
  logic            push_en;
  logic            branch, uncond;
  logic [PC_W-1:0] target;

  // Op decode with priority Halt > Ret > Call > Jmp > Br; Reset suppresses redirects.
  always_comb begin
    in_run   = (state_q == StRun) && !Reset;
    act_ret  = in_run && !bus.OpHalt && bus.OpRet;
    act_call = in_run && !bus.OpHalt && !bus.OpRet && bus.OpCall;
    act_jmp  = in_run && !bus.OpHalt && !bus.OpRet && !bus.OpCall && bus.OpJmp;
    act_br   = in_run && !bus.OpHalt && !bus.OpRet && !bus.OpCall && !bus.OpJmp && bus.OpBr;
  end

  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SpW'(STK_DEPTH));
  assign sp_top    = sp_q - SpW'(1);
  assign lut_rd    = lut_q[bus.LutIdx];
  assign stk_top   = stk_q[sp_top[StkAW-1:0]];
  assign push_val  = bus.ProgCtr + PC_W'(1);

  // Conditions use the registered flags only, so a same-cycle compare has no effect.
  always_comb begin
    cond_taken = 1'b0;
    case (bus.CondSel)
      2'b00:   cond_taken = z_q;
      2'b01:   cond_taken = !z_q;
      2'b10:   cond_taken = c_q;
      default: cond_taken = !c_q;
    endcase
  end

  always_comb begin
    branch = 1'b0;
    uncond = 1'b0;
    target = '0;
    if (act_ret && !stk_empty) begin
      branch = 1'b1;
      uncond = 1'b1;
      target = stk_top;
    end else if (act_call || act_jmp) begin
      branch = 1'b1;
      uncond = 1'b1;
      target = lut_rd;
    end else if (act_br && cond_taken) begin
      branch = 1'b1;
      target = lut_rd;
    end
  end

  // A Start that (re)enters RUN wipes per-program state; Halt wins over Start in RUN.
  assign start_clear = !Reset && bus.Start &&
                       ((state_q == StDone) || ((state_q == StRun) && !bus.OpHalt));
  assign push_en     = act_call && !stk_full && !start_clear;

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    c_d     = c_q;
    sp_d    = sp_q;
    serr_d  = serr_q;

    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.OpHalt) begin
          state_d = StDone;
        end
        if (bus.OpCmp) begin
          z_d = (bus.CmpA == bus.CmpB);
          c_d = (bus.CmpA < bus.CmpB);
        end
        if (act_call) begin
          if (stk_full) begin
            serr_d = 1'b1;
          end else begin
            sp_d = sp_q + SpW'(1);
          end
        end
        if (act_ret) begin
          if (stk_empty) begin
            serr_d = 1'b1;
          end else begin
            sp_d = sp_top;
          end
        end
      end
      StDone: begin
        if (bus.Start) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_clear) begin
      state_d = StRun;
      z_d     = 1'b0;
      c_d     = 1'b0;
      sp_d    = '0;
      serr_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      sp_q    <= '0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      c_q     <= c_d;
      sp_q    <= sp_d;
      serr_q  <= serr_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < LutDepth; i++) begin
        lut_q[i] <= '0;
      end
    end else if (bus.LutWe) begin
      lut_q[bus.LutIdx] <= bus.LutWData;
    end
  end

  // Stack storage needs no reset: entries are only read below the stack pointer.
  always_ff @(posedge Clk) begin
    if (!Reset && push_en) begin
      stk_q[sp_q[StkAW-1:0]] <= push_val;
    end
  end

  assign bus.Branch              = branch;
  assign bus.UnconditionalBranch = uncond;
  assign bus.Target              = target;
  assign bus.Running             = (state_q == StRun);
  assign bus.Done                = (state_q == StDone);
  assign bus.StackErr            = serr_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed, table-driven bench for branch_ctrl: one record per clock cycle,
// outputs checked mid-cycle before the edge that commits the inputs.
module tb_branch_ctrl;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned LUT_AW = 4;

  localparam logic [5:0] NOP  = 6'b000000;
  localparam logic [5:0] HALT = 6'b100000;
  localparam logic [5:0] RET  = 6'b010000;
  localparam logic [5:0] CALL = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000100;
  localparam logic [5:0] BR   = 6'b000010;
  localparam logic [5:0] CMP  = 6'b000001;

  localparam logic [1:0] EQ = 2'd0;
  localparam logic [1:0] NE = 2'd1;
  localparam logic [1:0] LT = 2'd2;
  localparam logic [1:0] GE = 2'd3;

  // Expected flags {Branch, UB, Running, Done, StackErr}
  localparam logic [4:0] E0    = 5'b00000;
  localparam logic [4:0] ERUN  = 5'b00100;
  localparam logic [4:0] EJB   = 5'b11100;
  localparam logic [4:0] EBR   = 5'b10100;
  localparam logic [4:0] EDONE = 5'b00010;
  localparam logic [4:0] ESERR = 5'b00001;

  typedef struct {
    string      name;
    logic       rst;
    logic       start;
    logic [5:0] ops;
    logic [1:0] cond;
    logic [7:0] pc;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] idx;
    logic       we;
    logic [7:0] wd;
    logic [4:0] e;
    logic [7:0] tgt;
  } vec_t;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;
  vec_t tbl[$];

  branch_ctrl_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();

  branch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .STK_DEPTH(4)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(string name, logic rst, logic start, logic [5:0] ops,
                              logic [1:0] cond, logic [7:0] pc, logic [7:0] a, logic [7:0] b,
                              logic [3:0] idx, logic we, logic [7:0] wd, logic [4:0] e,
                              logic [7:0] tgt);
    vec_t v;
    v.name = name; v.rst = rst; v.start = start; v.ops = ops; v.cond = cond;
    v.pc = pc; v.a = a; v.b = b; v.idx = idx; v.we = we; v.wd = wd; v.e = e; v.tgt = tgt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    Reset        = v.rst;
    bus.Start    = v.start;
    bus.OpHalt   = v.ops[5];
    bus.OpRet    = v.ops[4];
    bus.OpCall   = v.ops[3];
    bus.OpJmp    = v.ops[2];
    bus.OpBr     = v.ops[1];
    bus.OpCmp    = v.ops[0];
    bus.CondSel  = v.cond;
    bus.ProgCtr  = v.pc;
    bus.CmpA     = v.a;
    bus.CmpB     = v.b;
    bus.LutIdx   = v.idx;
    bus.LutWe    = v.we;
    bus.LutWData = v.wd;
  endtask

  task automatic check(input vec_t v);
    logic [12:0] got;
    logic [12:0] want;
    got  = {bus.Branch, bus.UnconditionalBranch, bus.Target, bus.Running, bus.Done,
            bus.StackErr};
    want = {v.e[4], v.e[3], v.tgt, v.e[2], v.e[1], v.e[0]};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got br=%0b ub=%0b tgt=%0d run=%0b done=%0b serr=%0b, want br=%0b ub=%0b tgt=%0d run=%0b done=%0b serr=%0b",
               v.name, got[12], got[11], got[10:3], got[2], got[1], got[0],
               want[12], want[11], want[10:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge Clk);
    drive(v);
    #1;
    check(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;

    drive(mk("init", 1, 0, NOP, EQ, 0, 0, 0, 0, 0, 0, E0, 0));
    repeat (2) @(posedge Clk);

    tbl.push_back(mk("rst_state",    1, 0, NOP,                 EQ,   0, 0, 0, 0, 0,   0, E0, 0));
    tbl.push_back(mk("jmp_idle",     0, 0, JMP,                 EQ,   0, 0, 0, 3, 1, 100, E0, 0));
    tbl.push_back(mk("wr_lut2",      0, 0, NOP,                 EQ,   0, 0, 0, 2, 1,  40, E0, 0));
    tbl.push_back(mk("wr_lut1",      0, 0, NOP,                 EQ,   0, 0, 0, 1, 1,  60, E0, 0));
    tbl.push_back(mk("start",        0, 1, NOP,                 EQ,   0, 0, 0, 0, 0,   0, E0, 0));
    tbl.push_back(mk("cmp_br_old_z", 0, 0, CMP | BR,            EQ,   0, 5, 5, 2, 0,   0, ERUN, 0));
    tbl.push_back(mk("jmp_run",      0, 0, JMP,                 EQ,   0, 0, 0, 3, 0,   0, EJB, 100));
    tbl.push_back(mk("br_eq",        0, 0, BR,                  EQ,   0, 0, 0, 2, 0,   0, EBR, 40));
    tbl.push_back(mk("br_ne",        0, 0, BR,                  NE,   0, 0, 0, 2, 0,   0, ERUN, 0));
    tbl.push_back(mk("cmp_3_9",      0, 0, CMP,                 EQ,   0, 3, 9, 0, 0,   0, ERUN, 0));
    tbl.push_back(mk("br_lt",        0, 0, BR,                  LT,   0, 0, 0, 2, 0,   0, EBR, 40));
    tbl.push_back(mk("br_ge",        0, 0, BR,                  GE,   0, 0, 0, 2, 0,   0, ERUN, 0));
    tbl.push_back(mk("call_10",      0, 0, CALL,                EQ,  10, 0, 0, 1, 0,   0, EJB, 60));
    tbl.push_back(mk("ret_11",       0, 0, RET,                 EQ,   0, 0, 0, 0, 0,   0, EJB, 11));
    tbl.push_back(mk("ret_empty",    0, 0, RET,                 EQ,   0, 0, 0, 0, 0,   0, ERUN, 0));
    tbl.push_back(mk("serr_sticky",  0, 0, NOP,                 EQ,   0, 0, 0, 0, 0,   0, ERUN | ESERR, 0));
    tbl.push_back(mk("restart",      0, 1, NOP,                 EQ,   0, 0, 0, 0, 0,   0, ERUN | ESERR, 0));
    tbl.push_back(mk("flags_clr",    0, 0, BR,                  GE,   0, 0, 0, 2, 0,   0, EBR, 40));
    tbl.push_back(mk("call_255",     0, 0, CALL,                EQ, 255, 0, 0, 1, 0,   0, EJB, 60));
    tbl.push_back(mk("ret_wrap",     0, 0, RET,                 EQ,   0, 0, 0, 0, 0,   0, EJB, 0));
    tbl.push_back(mk("call_20",      0, 0, CALL,                EQ,  20, 0, 0, 1, 0,   0, EJB, 60));
    tbl.push_back(mk("prio_ret",     0, 0, RET | CALL | JMP | BR, EQ, 99, 0, 0, 3, 0,  0, EJB, 21));
    tbl.push_back(mk("prio_call",    0, 0, CALL | JMP | BR,     EQ,  30, 0, 0, 3, 0,   0, EJB, 100));
    tbl.push_back(mk("ret_31",       0, 0, RET,                 EQ,   0, 0, 0, 0, 0,   0, EJB, 31));
    tbl.push_back(mk("prio_jmp",     0, 0, JMP | BR,            EQ,   0, 0, 0, 2, 0,   0, EJB, 40));
    tbl.push_back(mk("lut_old",      0, 0, JMP,                 EQ,   0, 0, 0, 2, 1,  77, EJB, 40));
    tbl.push_back(mk("lut_new",      0, 0, JMP,                 EQ,   0, 0, 0, 2, 0,   0, EJB, 77));
    tbl.push_back(mk("halt",         0, 0, HALT | RET | JMP,    EQ,   0, 0, 0, 3, 0,   0, ERUN, 0));
    tbl.push_back(mk("done_jmp",     0, 0, JMP,                 EQ,   0, 0, 0, 3, 0,   0, EDONE, 0));
    tbl.push_back(mk("done_start",   0, 1, NOP,                 EQ,   0, 0, 0, 0, 0,   0, EDONE, 0));
    tbl.push_back(mk("run_again",    0, 0, NOP,                 EQ,   0, 0, 0, 0, 0,   0, ERUN, 0));

    foreach (tbl[i]) begin
      step(tbl[i]);
    end

    // Five nested calls into a 4-deep stack: the fifth still jumps but is not saved.
    for (int k = 0; k < 5; k++) begin
      step(mk($sformatf("nest_call%0d", k), 0, 0, CALL, EQ, 8'(50 + k), 0, 0, 1, 0, 0,
              EJB, 60));
    end
    for (int k = 0; k < 4; k++) begin
      step(mk($sformatf("nest_ret%0d", k), 0, 0, RET, EQ, 0, 0, 0, 0, 0, 0,
              EJB | ESERR, 8'(54 - k)));
    end
    step(mk("nest_ret_empty", 0, 0, RET, EQ, 0, 0, 0, 0, 0, 0, ERUN | ESERR, 0));

    // Reset together with Start mid-run: back to IDLE with the LUT wiped.
    @(negedge Clk);
    drive(mk("rst_start", 1, 1, JMP, EQ, 0, 0, 0, 3, 0, 0, E0, 0));
    step(mk("post_rst_jmp", 0, 0, JMP, EQ, 0, 0, 0, 3, 0, 0, E0, 0));
    step(mk("start_again",  0, 1, NOP, EQ, 0, 0, 0, 0, 0, 0, E0, 0));
    step(mk("lut_cleared",  0, 0, JMP, EQ, 0, 0, 0, 3, 0, 0, EJB, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
